conv1d_stream: RTL and testbench

Streaming 1-D convolution engine for the CycleGAN generator and discriminator datapath. It accepts one fixed-point sample per cycle over a valid/ready handshake and holds a K-tap sliding window plus a loadable weight and bias set. It emits one saturated dot-product result for every S-th full window. It replaces the weight-only `conv1d` shell with a complete, back-pressurable, stride-aware pipeline.

---
 rtl/conv_pkg.sv | 24 ++
 rtl/sat_shift.sv | 30 +++
 rtl/conv1d_stream.sv | 193 +++++++++++++++++++
 tb/tb_conv1d_stream.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// conv_pkg: shared constants and types for the conv1d/conv2d MAC datapaths.
//   WIDTH_DATA / FRAC : default operand width and fractional bits (Q8.8).
//   SAT_MAX / SAT_MIN : saturation limits at the default width.
//   acc_width()       : accumulator width for a W-bit, K-tap dot product plus bias.
//   conv_state_e      : window FSM states (filling vs. emitting).
package conv_pkg;

    localparam int unsigned WIDTH_DATA = 16;
    localparam int unsigned FRAC       = 8;

    localparam logic [WIDTH_DATA-1:0] SAT_MAX = {1'b0, {(WIDTH_DATA-1){1'b1}}};
    localparam logic [WIDTH_DATA-1:0] SAT_MIN = {1'b1, {(WIDTH_DATA-1){1'b0}}};

    // Full-width products plus enough headroom for K of them and the aligned bias.
    function automatic int unsigned acc_width(input int unsigned w, input int unsigned k);
        return 2 * w + $clog2(k + 1);
    endfunction

    typedef enum logic {
        StFill,
        StRun
    } conv_state_e;

endpackage

// File: rtl/sat_shift.sv
// sat_shift: arithmetic right shift by SHIFT (floor toward -inf) followed by
// saturation of the result to a signed OUT_W-bit value.
//   in_i  : signed IN_W-bit accumulator
//   out_o : signed OUT_W-bit saturated result
module sat_shift #(
    parameter int unsigned IN_W  = 34,
    parameter int unsigned OUT_W = 16,
    parameter int unsigned SHIFT = 8
) (
    input  logic [IN_W-1:0]  in_i,
    output logic [OUT_W-1:0] out_o
);

    logic signed [IN_W-1:0] shifted;
    logic [IN_W-OUT_W:0]    top_bits;

    always_comb begin
        shifted  = $signed(in_i) >>> SHIFT;
        // The value fits iff every bit from the OUT_W sign bit upward agrees.
        top_bits = shifted[IN_W-1:OUT_W-1];
        if ((&top_bits) || !(|top_bits)) begin
            out_o = shifted[OUT_W-1:0];
        end else if (top_bits[IN_W-OUT_W]) begin
            out_o = {1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            out_o = {1'b0, {(OUT_W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/conv1d_stream.sv
// conv1d_stream: streaming K-tap 1-D convolution with stride S.
//   clk, rst_n            : clock, asynchronous active-low reset
//   w_en, w, b            : load weights (tap i = w[(i+1)*W-1 -: W]) and bias
//   din_valid/ready/din   : sample input handshake, din_last ends a frame
//   dout_valid/ready/dout : saturated result output handshake
// Stage 1 registers window x weight products, stage 2 the biased, shifted,
// saturated sum. The whole pipeline stalls while dout is held.
module conv1d_stream #(
    parameter int unsigned WIDTH_DATA = conv_pkg::WIDTH_DATA,
    parameter int unsigned FRAC       = conv_pkg::FRAC,
    parameter int unsigned K          = 15,
    parameter int unsigned S          = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    w_en,
    input  logic [K*WIDTH_DATA-1:0] w,
    input  logic [WIDTH_DATA-1:0]   b,
    input  logic                    din_valid,
    output logic                    din_ready,
    input  logic [WIDTH_DATA-1:0]   din,
    input  logic                    din_last,
    output logic                    dout_valid,
    input  logic                    dout_ready,
    output logic [WIDTH_DATA-1:0]   dout
);

    import conv_pkg::conv_state_e;
    import conv_pkg::StFill;
    import conv_pkg::StRun;
    import conv_pkg::acc_width;

    localparam int unsigned W  = WIDTH_DATA;
    localparam int unsigned AW = acc_width(W, K);
    localparam int unsigned CW = $clog2(K + 1);
    localparam int unsigned PW = (S > 1) ? $clog2(S) : 1;

    localparam logic [CW-1:0] CntFull   = CW'(K);
    localparam logic [CW-1:0] CntLast   = CW'(K - 1);
    localparam logic [PW-1:0] PhaseLast = PW'(S - 1);
    localparam logic [PW-1:0] PhaseRun  = PW'(1 % S);

    logic              adv;
    logic              accept;
    logic              emit;

    conv_state_e       state_q;
    logic [CW-1:0]     fill_cnt_q;
    logic [PW-1:0]     phase_q;

    logic [W-1:0]      w_q     [K];
    logic [W-1:0]      b_q;
    logic [W-1:0]      win_q   [K];
    logic [W-1:0]      win_d   [K];

    logic [2*W-1:0]    prod_d  [K];
    logic [2*W-1:0]    prod_q  [K];
    logic [W-1:0]      s1_bias_q;
    logic              s1_valid_q;

    logic [AW-1:0]     acc_sum;
    logic [W-1:0]      sat_out;
    logic [W-1:0]      dout_q;
    logic              dout_valid_q;

    assign adv        = !dout_valid_q || dout_ready;
    assign din_ready  = adv && !w_en;
    assign accept     = din_valid && din_ready;
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;

    // Window as it stands once din is shifted in; index 0 is the oldest sample.
    always_comb begin
        for (int i = 0; i < int'(K) - 1; i++) begin
            win_d[i] = win_q[i+1];
        end
        win_d[K-1] = din;
        for (int i = 0; i < int'(K); i++) begin
            prod_d[i] = {{W{win_d[i][W-1]}}, win_d[i]} * {{W{w_q[i][W-1]}}, w_q[i]};
        end
    end

    always_comb begin
        emit = 1'b0;
        if (state_q == StFill) begin
            emit = (fill_cnt_q == CntLast);
        end else begin
            emit = (phase_q == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StFill;
            fill_cnt_q <= '0;
            phase_q    <= '0;
        end else if (accept) begin
            if (din_last) begin
                state_q    <= StFill;
                fill_cnt_q <= '0;
                phase_q    <= '0;
            end else begin
                unique case (state_q)
                    StFill: begin
                        if (fill_cnt_q == CntLast) begin
                            state_q    <= StRun;
                            fill_cnt_q <= CntFull;
                            phase_q    <= PhaseRun;
                        end else begin
                            fill_cnt_q <= fill_cnt_q + CW'(1);
                        end
                    end
                    StRun: begin
                        phase_q <= (phase_q == PhaseLast) ? '0 : phase_q + PW'(1);
                    end
                endcase
            end
        end
    end

    // Weights load on any w_en edge; stage 1 captures the bias alongside the
    // products so results already in flight finish with the old set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(K); i++) begin
                w_q[i] <= '0;
            end
            b_q <= '0;
        end else if (w_en) begin
            for (int i = 0; i < int'(K); i++) begin
                w_q[i] <= w[i*W +: W];
            end
            b_q <= b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(K); i++) begin
                win_q[i] <= '0;
            end
        end else if (accept) begin
            for (int i = 0; i < int'(K); i++) begin
                win_q[i] <= win_d[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(K); i++) begin
                prod_q[i] <= '0;
            end
            s1_bias_q  <= '0;
            s1_valid_q <= 1'b0;
        end else if (adv) begin
            for (int i = 0; i < int'(K); i++) begin
                prod_q[i] <= prod_d[i];
            end
            s1_bias_q  <= b_q;
            s1_valid_q <= accept && emit;
        end
    end

    always_comb begin
        acc_sum = {{(AW-W){s1_bias_q[W-1]}}, s1_bias_q} << FRAC;
        for (int i = 0; i < int'(K); i++) begin
            acc_sum = acc_sum + {{(AW-2*W){prod_q[i][2*W-1]}}, prod_q[i]};
        end
    end

    sat_shift #(
        .IN_W  (AW),
        .OUT_W (W),
        .SHIFT (FRAC)
    ) u_sat_shift (
        .in_i  (acc_sum),
        .out_o (sat_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_valid_q <= 1'b0;
            dout_q       <= '0;
        end else if (adv) begin
            dout_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                dout_q <= sat_out;
            end
        end
    end

endmodule

// File: tb/tb_conv1d_stream.sv
// Bench for conv1d_stream: two K=3 instances (stride 1 and stride 2) see the
// same accepted sample stream. A frame-level reference model pushes expected
// results into per-instance queues; a monitor pops and compares on output.
module tb_conv1d_stream;

    localparam int W  = 16;
    localparam int FR = 8;
    localparam int KT = 3;
    localparam int S1 = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            w_en = 1'b0;
    logic [KT*W-1:0] w_bus = '0;
    logic [W-1:0]    b_bus = '0;
    logic            din_valid = 1'b0;
    logic            din_last = 1'b0;
    logic [W-1:0]    din = '0;
    logic            dout_ready0 = 1'b1;
    logic            din_ready0, din_ready1, dout_valid0, dout_valid1;
    logic            din_valid1, dout_ready1;
    logic [W-1:0]    dout0, dout1;

    always #5 clk = ~clk;

    // Instance 1 only sees samples instance 0 accepts, so both track one stream.
    assign din_valid1  = din_valid && din_ready0;
    assign dout_ready1 = 1'b1;

    conv1d_stream #(.WIDTH_DATA(W), .FRAC(FR), .K(KT), .S(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .w_en(w_en), .w(w_bus), .b(b_bus),
        .din_valid(din_valid), .din_ready(din_ready0), .din(din), .din_last(din_last),
        .dout_valid(dout_valid0), .dout_ready(dout_ready0), .dout(dout0)
    );

    conv1d_stream #(.WIDTH_DATA(W), .FRAC(FR), .K(KT), .S(S1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .w_en(w_en), .w(w_bus), .b(b_bus),
        .din_valid(din_valid1), .din_ready(din_ready1), .din(din), .din_last(din_last),
        .dout_valid(dout_valid1), .dout_ready(dout_ready1), .dout(dout1)
    );

    typedef struct {
        int val;
        int cyc;
        bit lat;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   hist[$];
    int   n_acc = 0;
    int   mw[KT];
    int   mb = 0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   lat_chk = 1'b0;
    int   rdy_mode = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    // Result of the current window from the frame's sample history.
    function automatic int ref_out();
        longint acc;
        int     base;
        acc  = longint'(mb) <<< FR;
        base = hist.size() - KT;
        for (int i = 0; i < KT; i++) begin
            acc += longint'(mw[i]) * longint'(hist[base+i]);
        end
        acc = acc >>> FR;
        if (acc > 32767) return 32767;
        if (acc < -32768) return -32768;
        return int'(acc);
    endfunction

    function automatic void model_accept(input int x, input bit last);
        exp_t e;
        hist.push_back(x);
        n_acc++;
        if (n_acc >= KT) begin
            e.val = ref_out();
            e.cyc = cyc;
            e.lat = lat_chk;
            q0.push_back(e);
            if ((n_acc - KT) % S1 == 0) begin
                e.lat = 1'b1;
                q1.push_back(e);
            end
        end
        if (last) begin
            hist.delete();
            n_acc = 0;
        end
    endfunction

    task automatic send(input logic [W-1:0] x, input bit last);
        bit done;
        done      = 1'b0;
        din_valid = 1'b1;
        din       = x;
        din_last  = last;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            if (din_ready0) begin
                model_accept(int'($signed(x)), last);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) chk("send_timeout", 0, 1);
        din_valid = 1'b0;
        din_last  = 1'b0;
    endtask

    task automatic load(input logic [KT*W-1:0] wb, input logic [W-1:0] bb);
        w_en  = 1'b1;
        w_bus = wb;
        b_bus = bb;
        @(negedge clk);
        chk("w_en_din_ready0", int'(din_ready0), 0);
        chk("w_en_din_ready1", int'(din_ready1), 0);
        @(posedge clk);
        for (int i = 0; i < KT; i++) mw[i] = int'($signed(wb[i*W +: W]));
        mb = int'($signed(bb));
        #1;
        w_en = 1'b0;
    endtask

    task automatic load_all(input logic [W-1:0] wv);
        logic [KT*W-1:0] wb;
        for (int i = 0; i < KT; i++) wb[i*W +: W] = wv;
        load(wb, '0);
    endtask

    task automatic drain();
        for (int i = 0; i < 80 && (q0.size() + q1.size()) != 0; i++) begin
            @(posedge clk);
            #1;
        end
        chk("drain_queues_empty", q0.size() + q1.size(), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] rnd_val();
        int t;
        if ($urandom_range(0, 1) == 0) begin
            t = int'($urandom_range(0, 1023)) - 512;
        end else begin
            t = int'($urandom);
        end
        return t[W-1:0];
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rdy_mode == 0) dout_ready0 = 1'b1;
        else if (rdy_mode == 1) dout_ready0 = 1'b0;
        else dout_ready0 = ($urandom_range(0, 3) != 0);
    end

    // Monitor: compares outputs against the scoreboard and checks the hold rule.
    initial begin
        exp_t       e;
        bit         stall0;
        logic [W-1:0] held0;
        stall0 = 1'b0;
        held0  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall0 = 1'b0;
            end else begin
                if (stall0) begin
                    chk("hold_valid0", int'(dout_valid0), 1);
                    chk("hold_dout0", int'($signed(dout0)), int'($signed(held0)));
                end
                if (dout_valid0 && !dout_ready0) chk("stall_din_ready0", int'(din_ready0), 0);
                if (dout_valid0 && dout_ready0) begin
                    if (q0.size() == 0) begin
                        chk("unexpected_dout0", int'($signed(dout0)), 99999);
                    end else begin
                        e = q0.pop_front();
                        chk("dout0", int'($signed(dout0)), e.val);
                        if (e.lat) chk("latency0", cyc - e.cyc, 2);
                    end
                end
                if (dout_valid1) begin
                    if (q1.size() == 0) begin
                        chk("unexpected_dout1", int'($signed(dout1)), 99999);
                    end else begin
                        e = q1.pop_front();
                        chk("dout1", int'($signed(dout1)), e.val);
                        if (e.lat) chk("latency1", cyc - e.cyc, 2);
                    end
                end
                stall0 = dout_valid0 && !dout_ready0;
                held0  = dout0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1);
    end

    initial begin
        logic [KT*W-1:0] wb;
        logic [W-1:0]    bb;
        int              len;

        for (int i = 0; i < KT; i++) mw[i] = 0;

        // Reset values.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dout_valid0", int'(dout_valid0), 0);
        chk("rst_dout0", int'(dout0), 0);
        chk("rst_din_ready0", int'(din_ready0), 1);
        chk("rst_dout_valid1", int'(dout_valid1), 0);
        chk("rst_din_ready1", int'(din_ready1), 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Unit weights, S=1 and S=2 streams.
        lat_chk = 1'b1;
        load_all(16'h0100);
        for (int i = 1; i <= 4; i++) send(W'(i * 256), i == 4);
        drain();
        for (int i = 1; i <= 6; i++) send(W'(i * 256), i == 6);
        drain();
        send(16'h0100, 1'b0);
        send(16'h0200, 1'b1);
        drain();

        // Saturation at both rails.
        load_all(16'h7FFF);
        for (int i = 1; i <= 3; i++) send(16'h7FFF, i == 3);
        load_all(16'h8000);
        for (int i = 1; i <= 3; i++) send(16'h7FFF, i == 3);
        drain();

        // Five-cycle backpressure mid-stream.
        lat_chk = 1'b0;
        load_all(16'h0100);
        fork
            begin
                for (int i = 1; i <= 10; i++) send(W'(i * 64 + 3), i == 10);
            end
            begin
                repeat (4) @(posedge clk);
                rdy_mode = 1;
                repeat (5) @(posedge clk);
                rdy_mode = 0;
            end
        join
        drain();

        // Weight reload between samples 4 and 5 of one frame.
        lat_chk = 1'b1;
        load_all(16'h0100);
        for (int i = 1; i <= 4; i++) send(W'(i * 256), 1'b0);
        load_all(16'h0200);
        for (int i = 5; i <= 8; i++) send(W'(i * 256), i == 8);
        drain();

        // Random frames, weights and output backpressure.
        lat_chk  = 1'b0;
        rdy_mode = 2;
        for (int f = 0; f < 10; f++) begin
            for (int i = 0; i < KT; i++) wb[i*W +: W] = rnd_val();
            bb = rnd_val();
            load(wb, bb);
            len = int'($urandom_range(1, 9));
            for (int j = 1; j <= len; j++) begin
                if (j == 3 && $urandom_range(0, 2) == 0) begin
                    for (int i = 0; i < KT; i++) wb[i*W +: W] = rnd_val();
                    load(wb, rnd_val());
                end
                send(rnd_val(), j == len);
            end
        end
        rdy_mode = 0;
        drain();

        // Reset with two results in flight.
        lat_chk = 1'b1;
        load_all(16'h0100);
        for (int i = 1; i <= 4; i++) send(W'(i * 256), 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst_dout_valid0", int'(dout_valid0), 0);
        chk("midrst_dout_valid1", int'(dout_valid1), 0);
        chk("midrst_dout0", int'(dout0), 0);
        q0.delete();
        q1.delete();
        hist.delete();
        n_acc = 0;
        for (int i = 0; i < KT; i++) mw[i] = 0;
        mb = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        load_all(16'h0100);
        send(16'h0500, 1'b0);
        send(16'h0600, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        chk("postrst_no_early_out", int'(dout_valid0), 0);
        send(16'h0700, 1'b1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
